// File: rtl/hub75_pkg.sv
// Shared HUB75 frame geometry, frame-RAM addressing and bank reset values,
// used by both the ingest side and the fetch/shift address generator.
package hub75_pkg;

  localparam int   COLS          = 128;
  localparam int   ROWS          = 128;
  localparam int   XW            = $clog2(COLS);
  localparam int   YW            = $clog2(ROWS);
  localparam int   PIX_W         = 24;
  localparam int   ADDR_W        = 1 + YW + XW;
  localparam logic WR_BANK_RST   = 1'b0;
  localparam logic DISP_BANK_RST = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WAIT_SWAP
  } ingest_state_t;

endpackage

// File: rtl/hub75_byte_to_pixel.sv
// Assembles R,G,B bytes into a 24-bit pixel; pix_vld is combinational with the
// accepted B byte, no backpressure of its own (caller qualifies load).
module hub75_byte_to_pixel
  import hub75_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sof,
  input  logic [7:0]       data,
  output logic [1:0]       phase,
  output logic             pix_vld,
  output logic [PIX_W-1:0] pix_dat
);

  logic [7:0] r_byte;
  logic [7:0] g_byte;

  // An SOF byte always restarts assembly as R, whatever the phase.
  assign pix_vld = load && !sof && (phase == 2'd2);
  assign pix_dat = {r_byte, g_byte, data};

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= 2'd0;
      r_byte <= 8'd0;
      g_byte <= 8'd0;
    end else if (load) begin
      if (sof || phase == 2'd0) begin
        r_byte <= data;
        phase  <= 2'd1;
      end else if (phase == 2'd1) begin
        g_byte <= data;
        phase  <= 2'd2;
      end else begin
        phase <= 2'd0;
      end
    end
  end

endmodule

// File: rtl/hub75_pixel_ingest.sv
// Byte stream to double-buffered frame RAM; write issues 1 cycle after the B byte.
// in_ready drops only while a complete frame waits for the display-side swap.
module hub75_pixel_ingest #(
  parameter int COLS = hub75_pkg::COLS,
  parameter int ROWS = hub75_pkg::ROWS,
  parameter int XW   = $clog2(COLS),
  parameter int YW   = $clog2(ROWS)
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  input  logic             frame_done,
  output logic             wr_en,
  output logic [YW+XW:0]   wr_addr,
  output logic [23:0]      wr_data,
  output logic             display_bank,
  output logic             swap_pending,
  output logic             sync_err,
  output logic [7:0]       frame_cnt
);

  import hub75_pkg::*;

  ingest_state_t    state;
  ingest_state_t    state_nxt;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             write_bank;
  logic             accept;
  logic             sof_hit;
  logic             load;
  logic             last_pix;
  logic [1:0]       phase;
  logic             pix_vld;
  logic [PIX_W-1:0] pix_dat;

  assign in_ready     = (state != WAIT_SWAP);
  assign swap_pending = (state == WAIT_SWAP);
  // Holding a single bank bit makes display/write complementarity structural.
  assign display_bank = ~write_bank;

  assign accept   = in_valid && in_ready;
  assign sof_hit  = accept && in_sof;
  assign load     = accept && (in_sof || state == RECV);
  assign last_pix = pix_vld && (x == XW'(COLS - 1)) && (y == YW'(ROWS - 1));

  hub75_byte_to_pixel u_b2p (
    .clk     (sys_clk),
    .rst     (rst),
    .load    (load),
    .sof     (in_sof),
    .data    (in_data),
    .phase   (phase),
    .pix_vld (pix_vld),
    .pix_dat (pix_dat)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (sof_hit)    state_nxt = RECV;
      RECV:      if (last_pix)   state_nxt = WAIT_SWAP;
      WAIT_SWAP: if (frame_done) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      write_bank <= WR_BANK_RST;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      sync_err   <= 1'b0;
      frame_cnt  <= 8'd0;
      x          <= '0;
      y          <= '0;
    end else begin
      state <= state_nxt;
      wr_en <= pix_vld;
      if (sof_hit) begin
        x <= '0;
        y <= '0;
        if (state == RECV && (phase != 2'd0 || x != '0 || y != '0)) sync_err <= 1'b1;
      end else if (pix_vld) begin
        wr_addr <= {write_bank, y, x};
        wr_data <= pix_dat;
        x       <= x + 1'b1;
        if (x == XW'(COLS - 1)) y <= y + 1'b1;
      end
      if (state == WAIT_SWAP && frame_done) begin
        write_bank <= ~write_bank;
        frame_cnt  <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hub75_pixel_ingest.sv
// Bench for hub75_pixel_ingest at COLS=4, ROWS=2: a frame-level reference model
// predicts every write, bank and status value cycle by cycle.
module tb_hub75_pixel_ingest;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int NPIX = COLS * ROWS;
  localparam int NB   = 3 * NPIX;
  localparam int AW   = 1 + $clog2(COLS) + $clog2(ROWS);

  logic          sys_clk = 1'b0;
  logic          rst, in_valid, in_sof, frame_done;
  logic [7:0]    in_data;
  logic          in_ready, wr_en, display_bank, swap_pending, sync_err;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [7:0]    frame_cnt;

  always #5 sys_clk = ~sys_clk;

  hub75_pixel_ingest #(.COLS(COLS), .ROWS(ROWS)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_ready     (in_ready),
    .frame_done   (frame_done),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .display_bank (display_bank),
    .swap_pending (swap_pending),
    .sync_err     (sync_err),
    .frame_cnt    (frame_cnt)
  );

  int tests = 0;
  int fails = 0;
  int nwrites;

  // Reference model: byte index within the current frame plus frame/bank bookkeeping.
  bit            m_wait, m_active, m_bank, m_err;
  int            m_idx, m_cnt;
  logic [7:0]    m_rgb [3];
  bit            exp_we;
  logic [AW-1:0] exp_addr;
  logic [23:0]   exp_data;

  typedef struct {
    int pre;
    int partial;
    bit fd_co;
    bit incr;
    bit gaps;
    int exp_writes;
    bit exp_err;
    bit exp_disp;
    int exp_cnt;
  } vec_t;

  vec_t tbl [4];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_wait = 0; m_active = 0; m_bank = 0; m_err = 0; m_idx = 0; m_cnt = 0;
  endfunction

  function automatic void model_byte(input bit s, input logic [7:0] d);
    int k;
    if (s) begin
      if (m_active && m_idx != 0) m_err = 1;
      m_active = 1;
      m_idx    = 0;
    end
    if (!m_active) return;
    m_rgb[m_idx % 3] = d;
    if (m_idx % 3 == 2) begin
      k        = (m_bank ? NPIX : 0) + m_idx / 3;
      exp_we   = 1;
      exp_addr = AW'(k);
      exp_data = {m_rgb[0], m_rgb[1], d};
    end
    m_idx++;
    if (m_idx == NB) begin
      m_active = 0;
      m_wait   = 1;
    end
  endfunction

  // One clock: drive at negedge, advance model, compare just after posedge.
  task automatic step(input bit v, input bit s, input logic [7:0] d, input bit fd, input bit r,
                      output bit acc);
    bit pre;
    in_valid = v; in_sof = s; in_data = d; frame_done = fd; rst = r;
    pre    = m_wait;
    acc    = v && !pre && !r;
    exp_we = 0;
    if (!r) check("in_ready", in_ready, !pre);
    if (r) model_reset();
    else begin
      if (fd && pre) begin
        m_bank = !m_bank;
        m_cnt++;
        m_wait = 0;
      end
      if (acc) model_byte(s, d);
    end
    @(posedge sys_clk);
    #1;
    if (wr_en) nwrites++;
    check("wr_en", wr_en, exp_we);
    if (exp_we || r) begin
      check("wr_addr", wr_addr, exp_we ? exp_addr : '0);
      check("wr_data", wr_data, exp_we ? exp_data : '0);
    end
    check("display_bank", display_bank, !m_bank);
    check("swap_pending", swap_pending, m_wait);
    check("sync_err", sync_err, m_err);
    check("frame_cnt", frame_cnt, m_cnt & 255);
    @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit s, input bit gaps, input bit fd_force);
    bit acc;
    if (gaps)
      repeat ($urandom_range(0, 2)) step(0, 0, 8'($urandom), $urandom_range(0, 7) == 0, 0, acc);
    step(1, s, d, fd_force || (gaps && $urandom_range(0, 7) == 0), 0, acc);
  endtask

  task automatic run_frame(input int pre, input int partial, input bit fd_co, input bit incr,
                           input bit gaps);
    bit acc;
    nwrites = 0;
    for (int j = 0; j < pre; j++) send_byte(8'($urandom), 0, gaps, 0);
    for (int j = 0; j < partial; j++) send_byte(8'($urandom), j == 0, gaps, 0);
    for (int j = 0; j < NB; j++)
      send_byte(incr ? 8'(j) : 8'($urandom), j == 0, gaps, fd_co && j == NB - 1);
    for (int j = 0; j < 3; j++) step(1, $urandom_range(0, 1), 8'($urandom), 0, 0, acc);
    check("swap_pending_hold", swap_pending, 1);
  endtask

  initial begin
    bit acc;
    int p;
    tbl[0] = '{0, 0, 0, 1, 0, 8, 0, 0, 1};
    tbl[1] = '{5, 0, 0, 0, 1, 8, 0, 1, 2};
    tbl[2] = '{0, 10, 0, 0, 1, 11, 1, 0, 3};
    tbl[3] = '{0, 0, 1, 0, 1, 8, 1, 1, 4};

    rst = 1; in_valid = 0; in_sof = 0; in_data = 0; frame_done = 0;
    model_reset();
    @(negedge sys_clk);
    step(0, 0, 8'h00, 0, 1, acc);
    step(0, 0, 8'h00, 0, 1, acc);
    check("reset_ready", in_ready, 1);
    check("reset_display_bank", display_bank, 1);

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].pre, tbl[i].partial, tbl[i].fd_co, tbl[i].incr, tbl[i].gaps);
      check("write_count", nwrites, tbl[i].exp_writes);
      check("sticky_err", sync_err, tbl[i].exp_err);
      check("bank_before_swap", display_bank, !tbl[i].exp_disp);
      check("ready_while_waiting", in_ready, 0);
      step(0, 0, 8'h00, 1, 0, acc);
      check("bank_after_swap", display_bank, tbl[i].exp_disp);
      check("cnt_after_swap", frame_cnt, tbl[i].exp_cnt);
      check("ready_after_swap", in_ready, 1);
    end

    step(0, 0, 8'h00, 1, 0, acc);
    check("idle_fd_bank", display_bank, tbl[3].exp_disp);
    check("idle_fd_cnt", frame_cnt, 4);

    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(0, 20);
      run_frame($urandom_range(0, 3), p, 0, 0, 1);
      check("write_count_rand", nwrites, p / 3 + NPIX);
      step(0, 0, 8'h00, 1, 0, acc);
    end

    for (int j = 0; j < 13; j++) send_byte(8'(j + 8'h40), j == 0, 1, 0);
    step(1, 0, 8'hAA, 0, 1, acc);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_display_bank", display_bank, 1);
    check("rst_swap_pending", swap_pending, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    run_frame(0, 0, 0, 0, 1);
    check("post_rst_writes", nwrites, NPIX);
    step(0, 0, 8'h00, 1, 0, acc);
    check("post_rst_bank", display_bank, 0);
    check("post_rst_cnt", frame_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
